// File: rtl/ps2_quad_mouse.sv
// ps2_quad_mouse: PS/2 mouse packets to round-robin quadrature outputs with saturating per-axis accumulators.
// Define PS2QUAD_WHEEL_EN to add the wheel (Z) axis.
module ps2_quad_mouse #(
   parameter int THRESH   = 16,
   parameter int ACC_W    = 12,
   parameter int DIV_W    = 16,
   parameter bit Y_INVERT = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic [24:0] ps2_mouse,
   input  logic [15:0] ps2_mouse_ext,
   output logic [1:0]  xout,
   output logic [1:0]  yout,
   output logic [1:0]  zout,
   output logic        button_l,
   output logic        button_r,
   output logic        button_m,
   output logic        busy
);
`ifdef PS2QUAD_WHEEL_EN
   localparam int NA = 3;
`else
   localparam int NA = 2;
`endif
   localparam int W = ACC_W + 2;
   localparam logic signed [W-1:0] MAX = W'((1 << (ACC_W - 1)) - 1);
   localparam logic signed [W-1:0] TH  = W'(THRESH);

   logic                old_stb, armed, stb, tick, sel_v;
   logic [DIV_W-1:0]    div;
   logic [1:0]          ptr, sel, k;
   logic [3:0]          pend;
   logic signed [W-1:0] d [NA];
   logic signed [W-1:0] yd;
   logic                unused;

   assign unused = ^{ps2_mouse[7:6], ps2_mouse[3], ps2_mouse_ext};
   // armed stays low for the first clk after reset so old_stb can load without a false strobe
   assign stb  = armed && (ps2_mouse[24] != old_stb);
   assign tick = ce && div == '0;
   assign d[0] = W'($signed({ps2_mouse[4], ps2_mouse[15:8]}));
   assign yd   = W'($signed({ps2_mouse[5], ps2_mouse[23:16]}));
   assign d[1] = Y_INVERT ? -yd : yd;
`ifdef PS2QUAD_WHEEL_EN
   assign d[2] = W'($signed(ps2_mouse_ext[7:0]));
`endif
   assign pend[3:NA] = '0;
   assign busy = |pend;

   always_comb begin
      sel   = ptr;
      sel_v = 1'b0;
      k     = ptr;
      for (int i = 0; i < NA; i++) begin
         if (!sel_v && pend[k]) begin
            sel   = k;
            sel_v = 1'b1;
         end
         k = (k == 2'(NA - 1)) ? 2'd0 : k + 2'd1;
      end
   end

   for (genvar a = 0; a < NA; a++) begin : g_ax
      logic signed [ACC_W-1:0] acc;
      logic signed [W-1:0]     cur, sum, nacc;
      logic [1:0]              q;
      logic                    step;
      assign cur     = W'(acc);
      assign pend[a] = cur >= TH || cur <= -TH;
      assign step    = tick && sel_v && sel == 2'(a);
      // delta and step are summed first so saturation sees the combined update
      assign sum  = cur + (stb ? d[a] : W'(0)) - (step ? (cur[W-1] ? -TH : TH) : W'(0));
      assign nacc = sum > MAX ? MAX : (sum < -MAX ? -MAX : sum);
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            acc <= '0;
            q   <= 2'b00;
         end else begin
            acc <= nacc[ACC_W-1:0];
            if (step) q <= cur[W-1] ? {q[0], ~q[1]} : {~q[0], q[1]};
         end
      end
   end

   assign xout = g_ax[0].q;
   assign yout = g_ax[1].q;
`ifdef PS2QUAD_WHEEL_EN
   assign zout = g_ax[2].q;
`else
   assign zout = 2'b00;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         old_stb <= 1'b0;
         armed   <= 1'b0;
         div     <= '0;
         ptr     <= 2'd0;
         {button_m, button_r, button_l} <= 3'b111;
      end else begin
         old_stb <= ps2_mouse[24];
         armed   <= 1'b1;
         if (ce) div <= div + DIV_W'(1);
         if (stb) {button_m, button_r, button_l} <= ~ps2_mouse[2:0];
         if (tick && sel_v) ptr <= (sel == 2'(NA - 1)) ? 2'd0 : sel + 2'd1;
      end
   end
endmodule

// File: tb/tb_ps2_quad_mouse.sv
// tb_ps2_quad_mouse: directed vector table plus hand sequences for strobe, cancel, saturation and reset.
module tb_ps2_quad_mouse;
   logic        clk = 1'b0, reset = 1'b1, ce = 1'b0;
   logic [24:0] ps2_mouse = '0;
   logic [15:0] ps2_mouse_ext = '0;
   logic [1:0]  xout, yout, zout;
   logic        button_l, button_r, button_m, busy;
   int          nvec = 0, nmis = 0;

   ps2_quad_mouse #(.THRESH(16), .ACC_W(12), .DIV_W(2), .Y_INVERT(1'b0)) dut (
      .clk(clk), .reset(reset), .ce(ce), .ps2_mouse(ps2_mouse), .ps2_mouse_ext(ps2_mouse_ext),
      .xout(xout), .yout(yout), .zout(zout),
      .button_l(button_l), .button_r(button_r), .button_m(button_m), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         x, y;
      logic [7:0] ext;
      logic [2:0] btn;
      int         nt;
      logic [1:0] ex, ey, ez;
      logic [2:0] eb;
      logic       ebusy;
   } vec_t;
   vec_t tv [14];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic rst_dut(input logic tgl);
      reset = 1'b1;
      ce = 1'b0;
      ps2_mouse = {tgl, 24'h0};
      ps2_mouse_ext = '0;
      cyc();
      cyc();
      reset = 1'b0;
      cyc();
   endtask

   task automatic pkt(input int x, input int y, input logic [7:0] ext, input logic [2:0] btn);
      ps2_mouse[15:8]  = x[7:0];
      ps2_mouse[4]     = x[8];
      ps2_mouse[23:16] = y[7:0];
      ps2_mouse[5]     = y[8];
      ps2_mouse[2:0]   = btn;
      ps2_mouse_ext    = {8'h00, ext};
      ps2_mouse[24]    = ~ps2_mouse[24];
      cyc();
   endtask

   task automatic ticks(input int n);
      ce = 1'b1;
      repeat (4 * n) cyc();
      ce = 1'b0;
   endtask

   initial begin
      logic [1:0] eq;
      tv[0]  = '{48,   0,   8'h00, 3'b001, 0, 2'b00, 2'b00, 2'b00, 3'b110, 1'b1};
      tv[1]  = '{48,   0,   8'h00, 3'b010, 1, 2'b10, 2'b00, 2'b00, 3'b101, 1'b1};
      tv[2]  = '{48,   0,   8'h00, 3'b100, 2, 2'b11, 2'b00, 2'b00, 3'b011, 1'b1};
      tv[3]  = '{48,   0,   8'h00, 3'b000, 3, 2'b01, 2'b00, 2'b00, 3'b111, 1'b0};
      tv[4]  = '{48,   0,   8'h00, 3'b000, 4, 2'b01, 2'b00, 2'b00, 3'b111, 1'b0};
      tv[5]  = '{32,   -32, 8'h00, 3'b000, 1, 2'b10, 2'b00, 2'b00, 3'b111, 1'b1};
      tv[6]  = '{32,   -32, 8'h00, 3'b000, 2, 2'b10, 2'b01, 2'b00, 3'b111, 1'b1};
      tv[7]  = '{32,   -32, 8'h00, 3'b000, 4, 2'b11, 2'b11, 2'b00, 3'b111, 1'b0};
      tv[8]  = '{-16,  0,   8'h00, 3'b111, 1, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
      tv[9]  = '{15,   0,   8'h00, 3'b000, 3, 2'b00, 2'b00, 2'b00, 3'b111, 1'b0};
      tv[10] = '{-256, 0,   8'h00, 3'b000, 5, 2'b01, 2'b00, 2'b00, 3'b111, 1'b1};
      tv[11] = '{0,    255, 8'h00, 3'b000, 2, 2'b00, 2'b11, 2'b00, 3'b111, 1'b1};
`ifdef PS2QUAD_WHEEL_EN
      tv[12] = '{16,   0,   8'hF0, 3'b000, 2, 2'b10, 2'b00, 2'b01, 3'b111, 1'b0};
      tv[13] = '{32,   0,   8'hF0, 3'b000, 2, 2'b10, 2'b00, 2'b01, 3'b111, 1'b1};
`else
      tv[12] = '{16,   0,   8'hF0, 3'b000, 2, 2'b10, 2'b00, 2'b00, 3'b111, 1'b0};
      tv[13] = '{32,   0,   8'hF0, 3'b000, 2, 2'b11, 2'b00, 2'b00, 3'b111, 1'b0};
`endif

      for (int i = 0; i < 14; i++) begin
         rst_dut(1'b0);
         pkt(tv[i].x, tv[i].y, tv[i].ext, tv[i].btn);
         ticks(tv[i].nt);
         chk($sformatf("v%0d xout", i), xout, tv[i].ex);
         chk($sformatf("v%0d yout", i), yout, tv[i].ey);
         chk($sformatf("v%0d zout", i), zout, tv[i].ez);
         chk($sformatf("v%0d buttons", i), {button_m, button_r, button_l}, tv[i].eb);
         chk($sformatf("v%0d busy", i), busy, tv[i].ebusy);
      end

      rst_dut(1'b1);
      ps2_mouse[15:8] = 8'd48;
      ps2_mouse[2:0]  = 3'b111;
      repeat (3) cyc();
      chk("no strobe buttons", {button_m, button_r, button_l}, 3'b111);
      chk("no strobe busy", busy, 0);
      ticks(2);
      chk("no strobe xout", xout, 2'b00);

      rst_dut(1'b0);
      pkt(32, 0, 8'h00, 3'b000);
      chk("cancel busy pre", busy, 1);
      pkt(-32, 0, 8'h00, 3'b000);
      chk("cancel busy", busy, 0);
      ticks(4);
      chk("cancel xout", xout, 2'b00);

      rst_dut(1'b0);
      repeat (200) pkt(255, 0, 8'h00, 3'b000);
      chk("sat busy", busy, 1);
      eq = 2'b00;
      for (int i = 0; i < 127; i++) begin
         chk($sformatf("sat busy t%0d", i), busy, 1);
         ticks(1);
         eq = {~eq[0], eq[1]};
         chk($sformatf("sat xout t%0d", i), xout, eq);
      end
      chk("sat busy end", busy, 0);
      ticks(2);
      chk("sat xout idle", xout, eq);

      rst_dut(1'b0);
      pkt(48, 0, 8'h00, 3'b111);
      ticks(1);
      chk("mid xout pre", xout, 2'b10);
      #2 reset = 1'b1;
      #1;
      chk("async xout", xout, 2'b00);
      chk("async busy", busy, 0);
      chk("async buttons", {button_m, button_r, button_l}, 3'b111);
      rst_dut(ps2_mouse[24]);
      ticks(3);
      chk("post reset xout", xout, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
